// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_pkg                                             |
// | Description : Shared encodings for the RV32M EX-stage mul/div unit:  |
// |               funct3 op codes, FSM states and the signed-minimum     |
// |               operand pattern used by the overflow fast path.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package muldiv_pkg;

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  // Most-negative value left-aligned in 64 bits; slice the top XLEN bits
  localparam logic [63:0] MD_SIGNED_MIN64 = 64'h8000_0000_0000_0000;

endpackage
`default_nettype wire

// File: rtl/ex_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ex_div_step                                            |
// | Description : One combinational restoring-division step: shift the  |
// |               next dividend bit into the partial remainder and       |
// |               subtract the divisor if it fits.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ex_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dividend_bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            quo_bit_o
);

  // rem_i < divisor, so the shifted value fits in XLEN+1 bits and a
  // non-negative difference always fits back in XLEN bits.
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  assign w_shift   = {rem_i, dividend_bit_i};
  assign w_diff    = w_shift - {1'b0, divisor_i};
  assign quo_bit_o = ~w_diff[XLEN];
  assign rem_o     = quo_bit_o ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ex_muldiv                                              |
// | Description : Iterative RV32M multiply/divide unit in EX. One bit    |
// |               per cycle shift-add multiply and restoring divide on   |
// |               operand magnitudes, with sign fix-up at completion.    |
// |               Divide-by-zero and signed overflow finish in one cycle.|
// | Config      : define MULDIV_FAST_MUL_EN for a single-cycle           |
// |               combinational multiplier (divide path unchanged).      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic [XLEN-1:0]        rs1,
  input  logic [XLEN-1:0]        rs2,
  input  logic [RFIDX_WIDTH-1:0] rd_index,
  input  logic                   kill,
  output logic                   busy,
  output logic                   stall_req,
  output logic                   done,
  output logic [XLEN-1:0]        result,
  output logic [RFIDX_WIDTH-1:0] rd_index_out
);

  localparam int              CW     = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   C_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] C_SMIN = MD_SIGNED_MIN64[63 -: XLEN];

  md_state_e              state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [RFIDX_WIDTH-1:0] rd_q, rd_d;
  logic [XLEN-1:0]        a_q, a_d;       // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0]        b_q, b_d;       // divisor magnitude
  logic [2*XLEN-1:0]      prod_q, prod_d; // {accumulator, remaining multiplier bits}
  logic [XLEN-1:0]        rem_q, rem_d;
  logic                   neg_q, neg_d;   // final result must be negated
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [XLEN-1:0]        result_q, result_d;
  logic                   busy_q, done_q;

  logic            w_s1_signed, w_s2_signed;
  logic            w_neg1, w_neg2, w_res_neg;
  logic [XLEN-1:0] w_mag1, w_mag2;
  logic            w_div_zero, w_ovf;

  // Decode operand signedness from the incoming funct3
  always_comb begin
    w_s1_signed = 1'b0;
    w_s2_signed = 1'b0;
    case (op)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
        w_s1_signed = 1'b1;
        w_s2_signed = 1'b1;
      end
      MD_MULHSU:                 w_s1_signed = 1'b1;
      MD_MULHU, MD_DIVU, MD_REMU: w_s1_signed = 1'b0;
      default:                   w_s1_signed = 1'b0;
    endcase
  end

  assign w_neg1     = w_s1_signed & rs1[XLEN-1];
  assign w_neg2     = w_s2_signed & rs2[XLEN-1];
  assign w_mag1     = w_neg1 ? -rs1 : rs1;
  assign w_mag2     = w_neg2 ? -rs2 : rs2;
  // Remainder takes the dividend sign; everything else takes the xor
  assign w_res_neg  = (op[2] & op[1]) ? w_neg1 : (w_neg1 ^ w_neg2);
  assign w_div_zero = (rs2 == {XLEN{1'b0}});
  assign w_ovf      = w_s1_signed & op[2] & (rs1 == C_SMIN) & (rs2 == {XLEN{1'b1}});

  // Shift-add step: add multiplicand when the current multiplier bit is set
  logic [XLEN-1:0]   w_addend;
  logic [XLEN:0]     w_mul_acc;
  logic [2*XLEN-1:0] w_prod_nx, w_prod_sgn;
  logic [XLEN-1:0]   w_mul_res;

  assign w_addend   = prod_q[0] ? a_q : {XLEN{1'b0}};
  assign w_mul_acc  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, w_addend};
  assign w_prod_nx  = {w_mul_acc, prod_q[XLEN-1:1]};
  assign w_prod_sgn = neg_q ? -w_prod_nx : w_prod_nx;
  assign w_mul_res  = (op_q == MD_MUL) ? w_prod_sgn[XLEN-1:0] : w_prod_sgn[2*XLEN-1:XLEN];

  // Restoring divide step on the MSB of the dividend register
  logic [XLEN-1:0] w_rem_nx, w_quo_nx, w_div_val, w_div_res;
  logic            w_qbit;

  ex_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i          (rem_q),
    .dividend_bit_i (a_q[XLEN-1]),
    .divisor_i      (b_q),
    .rem_o          (w_rem_nx),
    .quo_bit_o      (w_qbit)
  );

  assign w_quo_nx  = {a_q[XLEN-2:0], w_qbit};
  assign w_div_val = op_q[1] ? w_rem_nx : w_quo_nx;
  assign w_div_res = neg_q ? -w_div_val : w_div_val;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod, w_fast_sgn;
  logic [XLEN-1:0]   w_fast_res;

  assign w_fast_prod = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
  assign w_fast_sgn  = w_res_neg ? -w_fast_prod : w_fast_prod;
  assign w_fast_res  = (op == MD_MUL) ? w_fast_sgn[XLEN-1:0] : w_fast_sgn[2*XLEN-1:XLEN];
`endif

  // Next-state, datapath update and result capture
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          op_d   = op;
          rd_d   = rd_index;
          a_d    = w_mag1;
          b_d    = w_mag2;
          neg_d  = w_res_neg;
          cnt_d  = '0;
          rem_d  = '0;
          prod_d = {{XLEN{1'b0}}, w_mag2};
          if (!op[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            state_d  = S_DONE;
            result_d = w_fast_res;
`else
            state_d  = S_MUL;
`endif
          end else if (w_div_zero) begin
            state_d  = S_DONE;
            result_d = op[1] ? rs1 : {XLEN{1'b1}};
          end else if (w_ovf) begin
            state_d  = S_DONE;
            result_d = op[1] ? {XLEN{1'b0}} : rs1;
          end else begin
            state_d  = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          prod_d = w_prod_nx;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            state_d  = S_DONE;
            result_d = w_mul_res;
          end
        end
      end
      S_DIV: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          a_d   = w_quo_nx;
          rem_d = w_rem_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            state_d  = S_DONE;
            result_d = w_div_res;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= (state_d == S_MUL) || (state_d == S_DIV);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign stall_req    = (start && (state_q == S_IDLE) && !kill) ||
                        (state_q == S_MUL) || (state_q == S_DIV);
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign rd_index_out = rd_q;

endmodule
`default_nettype wire
